// File: rtl/dajiang13_dec.sv
// Sequential decoder for the x251 encoder: restoring shift-subtract division,
// one quotient bit per clock, with a flag marking legal encoder code words.
module dajiang13_dec #(
    parameter int DIVISOR = 251,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quot,
    output logic [7:0]    rem,
    output logic [7:0]    a_out,
    output logic          exact
);

    localparam int          CW   = $clog2(DW);
    localparam logic [8:0]  DIV9 = 9'(DIVISOR);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state, state_nx;
    logic [DW-1:0] dvd;
    logic [DW-1:0] q;
    logic [8:0]    r;
    logic [CW-1:0] cnt;
    logic [8:0]    r_nx;
    logic          q_bit;
    logic [DW-1:0] q_nx;
    logic          accept;
    logic          last_step;

    // One restoring step: returns {quotient bit, new partial remainder}.
    // The remainder is 9 bits wide so the shifted value never wraps.
    function automatic logic [9:0] div_step(input logic [8:0] r_in, input logic msb);
        logic [8:0] r_sh;
        r_sh = {r_in[7:0], msb};
        if (r_sh >= DIV9)
            div_step = {1'b1, r_sh - DIV9};
        else
            div_step = {1'b0, r_sh};
    endfunction

    always_comb begin
        {q_bit, r_nx} = div_step(r, dvd[DW-1]);
        q_nx          = {q[DW-2:0], q_bit};
    end

    assign accept    = (state == IDLE) && in_valid;
    assign last_step = (state == CALC) && (cnt == LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid)  state_nx = CALC;
            CALC: if (cnt == LAST) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Working registers are fully reloaded on accept, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            dvd <= in_data;
            r   <= '0;
            q   <= '0;
        end else if (state == CALC) begin
            dvd <= {dvd[DW-2:0], 1'b0};
            r   <= r_nx;
            q   <= q_nx;
        end
    end

    // Step counter and result registers; results change only on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            quot  <= '0;
            rem   <= '0;
            a_out <= '0;
            exact <= 1'b0;
        end else begin
            if (accept)
                cnt <= '0;
            else if (state == CALC)
                cnt <= cnt + 1'b1;
            if (last_step) begin
                quot  <= q_nx;
                rem   <= r_nx[7:0];
                a_out <= q_nx[7:0];
                exact <= (r_nx == 9'd0) && (q_nx[DW-1:8] == '0);
            end
        end
    end

endmodule

// File: tb/tb_dajiang13_dec.sv
// Bench for dajiang13_dec: directed cases, backpressure, mid-operation reset
// and a random/encoded-value sweep against an arithmetic division model.
module tb_dajiang13_dec;

    localparam int DIV = 251;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quot;
    logic [7:0]  rem;
    logic [7:0]  a_out;
    logic        exact;

    int checks = 0;
    int errors = 0;

    dajiang13_dec #(.DIVISOR(DIV), .DW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .a_out     (a_out),
        .exact     (exact)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division of the code word.
    task automatic model(input logic [15:0] w, output int eq, output int er, output logic ex);
        eq = int'(w) / DIV;
        er = int'(w) % DIV;
        ex = (er == 0) && (eq <= 255);
    endtask

    // Offer a word, time the result, compare it, then let the handshake complete
    // (out_ready must already be 1 unless the caller handles release itself).
    task automatic txn(input logic [15:0] w, input bit check_lat, input bit release_out);
        int n, eq, er;
        logic ex;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (check_lat) chk("latency", 32'(n), 32'd16);
        else           chk("out_valid_seen", 32'(out_valid), 32'd1);
        model(w, eq, er, ex);
        chk("quot", 32'(quot), 32'(eq));
        chk("rem", 32'(rem), 32'(er));
        chk("a_out", 32'(a_out), 32'(eq & 255));
        chk("exact", 32'(exact), 32'(ex));
        if (release_out) begin
            @(negedge clk);
            chk("back_to_idle", {30'd0, in_ready, out_valid}, 32'b10);
        end
    endtask

    initial begin
        int eq, er;
        logic ex;
        logic [15:0] held_q;
        logic [7:0]  held_r;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quot", 32'(quot), 32'd0);
        chk("rst_rem", 32'(rem), 32'd0);
        chk("rst_a_out", 32'(a_out), 32'd0);
        chk("rst_exact", 32'(exact), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed values
        txn(16'd64005, 1'b1, 1'b1);
        chk("d64005_a", 32'(a_out), 32'd255);
        chk("d64005_exact", 32'(exact), 32'd1);
        txn(16'd0, 1'b1, 1'b1);
        chk("d0_exact", 32'(exact), 32'd1);
        txn(16'd502, 1'b1, 1'b1);
        chk("d502_quot", 32'(quot), 32'd2);
        txn(16'd65535, 1'b1, 1'b1);
        chk("d65535_quot", 32'(quot), 32'd261);
        chk("d65535_rem", 32'(rem), 32'd24);
        chk("d65535_a", 32'(a_out), 32'd5);
        chk("d65535_exact", 32'(exact), 32'd0);
        txn(16'd250, 1'b1, 1'b1);
        chk("d250_rem", 32'(rem), 32'd250);
        chk("d250_exact", 32'(exact), 32'd0);

        // Backpressure: stray in_valid during CALC/DONE must not be taken
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'd1255;
        @(negedge clk);
        in_data = 16'd502;
        repeat (3) @(negedge clk);
        chk("calc_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        model(16'd1255, eq, er, ex);
        held_q = 16'(eq);
        held_r = 8'(er);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_quot", 32'(quot), 32'(held_q));
            chk("bp_rem", 32'(rem), 32'(held_r));
            chk("bp_exact", 32'(exact), 32'(ex));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {30'd0, in_ready, out_valid}, 32'b10);
        txn(16'd502, 1'b1, 1'b1);

        // Reset during CALC clears everything at once
        in_valid = 1'b1;
        in_data  = 16'd40000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_quot", 32'(quot), 32'd0);
        chk("mid_rst_rem", 32'(rem), 32'd0);
        chk("mid_rst_exact", 32'(exact), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(16'd251, 1'b1, 1'b1);
        chk("post_rst_quot", 32'(quot), 32'd1);
        chk("post_rst_exact", 32'(exact), 32'd1);

        // Every legal code word recovers its source value
        for (int a = 0; a < 256; a++) begin
            txn(16'(a * DIV), 1'b0, 1'b0);
            chk("enc_a", 32'(a_out), 32'(a));
            chk("enc_exact", 32'(exact), 32'd1);
        end

        // Random code words
        for (int i = 0; i < 1000; i++)
            txn(16'($urandom), 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dajiang13_dec.md
Name: dajiang13_dec

Overview:
- Sequential decoder for the ×251 encoder in the same design.
- Accepts a 16-bit code word and recovers the 8-bit source value by restoring shift-subtract division by 251, one quotient bit per cycle.
- Reports full quotient, remainder and an "exact" flag marking whether the code word is a legal encoder output.
- Sits downstream of the encoder path; valid/ready handshake on both sides.

Parameters:
- DIVISOR, 251, constant divisor; 8-bit, legal range 1..255.
- DW, 16, dividend / quotient width; fixed at 16, not intended for override.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  code word present on in_data.
- in_ready  output  1  block can accept a code word.
- in_data  input  16  code word B.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes the result.
- quot  output  16  floor(in_data / DIVISOR).
- rem  output  8  in_data mod DIVISOR.
- a_out  output  8  quot[7:0], the recovered source value A.
- exact  output  1  1 when rem==0 and quot<=255, i.e. in_data is a legal encoder output.

Behaviour:
- Reset: asynchronous on rst_n low; state IDLE, in_ready=1, out_valid=0, quot=0, rem=0, a_out=0, exact=0, bit counter=0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready at an edge, latch in_data, clear working remainder (9 bits) and quotient, counter=0, go to CALC.
  - CALC: in_ready=0, out_valid=0. Each edge performs one step:
    - r' = {r[7:0], dividend MSB}; dividend shifts left.
    - If r' >= DIVISOR, subtract and shift 1 into the quotient; else keep r' and shift in 0.
    - Counter increments. On the 16th step (counter==15) go to DONE.
  - DONE: out_valid=1. quot, rem, a_out and exact are registered and stable while out_valid=1. On out_valid&out_ready at an edge, go to IDLE. out_valid holds indefinitely while out_ready=0.
- Latency and throughput:
  - Accept at edge k → out_valid high after edge k+16.
  - No accept in DONE, even with out_ready=1. Minimum period between accepts is 18 cycles.
- Width rules:
  - Working remainder is 9 bits, so the compare cannot overflow.
  - Final remainder is always < DIVISOR and fits in 8 bits.
  - Quotient is unsigned 16 bits. For DIVISOR=251, max quot=261.
- Outputs are updated only on entry to DONE. Values from the previous result persist through IDLE/CALC; consumers qualify them with out_valid.
- in_data and in_valid are ignored outside IDLE.
- out_ready is ignored outside DONE.
- Reset mid-operation: any state returns to IDLE immediately. Partial results are discarded and all outputs are cleared.
- DIVISOR=1 is legal (quot=in_data, rem=0). DIVISOR=0 is illegal and need not be handled.

Test Plan:
- Reset, then send in_data=64005 with out_ready=1 → out_valid 16 cycles after accept; quot=255, rem=0, a_out=255, exact=1.
- in_data=0 → quot=0, rem=0, a_out=0, exact=1. in_data=502 → quot=2, rem=0, exact=1.
- in_data=65535 → quot=261, rem=24, a_out=5, exact=0. in_data=250 → quot=0, rem=250, exact=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - Outputs stay stable and in_ready stays 0.
  - A new in_valid presented during CALC/DONE is not accepted.
  - Release out_ready → IDLE on the next cycle, then accept.
- Reset mid-CALC: assert rst_n=0 at step 7 → out_valid=0, outputs=0, in_ready=1 immediately; the next transaction (in_data=251) gives quot=1, rem=0, exact=1.
- Random sweep: 1000 random 16-bit words plus all 256 encoded values A*251 → quot/rem match the division model; exact=1 exactly for encoded values; a_out==A for each.
